// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry record, field limits and helpers for fetch_queue.
// The entry record is sized for the largest supported configuration
// (32-byte lines, 16-bit ids); narrower instances leave the upper bits at zero.
package fetch_pkg;

  localparam int unsigned FQ_MAX_LINE_BYTES = 32;
  localparam int unsigned FQ_MAX_WW         = 6;
  localparam int unsigned FQ_MAX_ID_W       = 16;
  localparam int unsigned FQ_MAX_BW         = 8 * FQ_MAX_LINE_BYTES;

  typedef struct packed {
    logic [FQ_MAX_BW-1:0]   bytes;
    logic [31:0]            pc;
    logic [FQ_MAX_WW-1:0]   width;
    logic                   bpred_taken;
    logic [31:0]            bpred_tgt;
    logic [FQ_MAX_ID_W-1:0] id;
  } fq_entry_t;

  // Width of a byte-count field able to hold 0..line_bytes.
  function automatic int unsigned fq_ww(input int unsigned line_bytes);
    return $clog2(line_bytes) + 1;
  endfunction

  // Zero every byte whose index is at or beyond the valid byte count.
  function automatic logic [FQ_MAX_BW-1:0] fq_mask_bytes(
    input logic [FQ_MAX_BW-1:0] bytes,
    input int unsigned          width
  );
    logic [FQ_MAX_BW-1:0] masked;
    masked = '0;
    for (int unsigned i = 0; i < FQ_MAX_LINE_BYTES; i++) begin
      if (i < width) masked[8*i +: 8] = bytes[8*i +: 8];
    end
    return masked;
  endfunction

endpackage

// File: rtl/fetch_queue_ptr.sv
// fq_ptr: wrap-around queue pointer (modulo DEPTH) with increment and clear.
module fq_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_inc,
  input  logic                     i_clr,
  output logic [$clog2(DEPTH)-1:0] o_ptr
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] r_ptr;

  // Pointer register: clear wins over increment, wraps from DEPTH-1 to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      if (r_ptr == AW'(DEPTH - 1)) r_ptr <= '0;
      else                         r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch line queue between fetch and decode.
// Optional build macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards a
// qualifying input line straight to the outputs in the same cycle.
// ID_W must not exceed fetch_pkg::FQ_MAX_ID_W.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ID_W       = 4
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [8*LINE_BYTES-1:0]       in_bytes,
  input  logic [31:0]                   in_pc,
  input  logic [fq_ww(LINE_BYTES)-1:0]  in_width,
  input  logic                          in_bpred_taken,
  input  logic [31:0]                   in_bpred_tgt,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [8*LINE_BYTES-1:0]       out_bytes,
  output logic [31:0]                   out_pc,
  output logic [fq_ww(LINE_BYTES)-1:0]  out_width,
  output logic                          out_bpred_taken,
  output logic [31:0]                   out_bpred_tgt,
  output logic [ID_W-1:0]               out_id,
  input  logic                          out_ready,
  input  logic                          flush,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned WW = fq_ww(LINE_BYTES);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 8 * LINE_BYTES;

  logic [CW-1:0]   r_count;
  logic [ID_W-1:0] r_id;
  logic            r_rst_done;
  fq_entry_t       r_mem [DEPTH];

  logic [AW-1:0]   w_wr_ptr;
  logic [AW-1:0]   w_rd_ptr;
  fq_entry_t       w_in_entry;
  fq_entry_t       w_head;
  fq_entry_t       w_out_entry;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_enq;
  logic            w_deq;
  logic            w_bypass;
  logic            w_bypass_take;
  logic            w_wr;
  logic            w_unused;

  // Build the entry record for the offered line; bytes past in_width are zeroed.
  always_comb begin
    w_in_entry                  = '0;
    w_in_entry.bytes[BW-1:0]    = in_bytes;
    w_in_entry.bytes            = fq_mask_bytes(w_in_entry.bytes, 32'(in_width));
    w_in_entry.pc               = in_pc;
    w_in_entry.width[WW-1:0]    = in_width;
    w_in_entry.bpred_taken      = in_bpred_taken;
    w_in_entry.bpred_tgt        = in_bpred_tgt;
    w_in_entry.id[ID_W-1:0]     = r_id;
  end

  assign w_in_ready = r_rst_done & (r_count < CW'(DEPTH));
  assign w_enq      = in_valid & w_in_ready & ~flush & (in_width != '0);
  assign w_deq      = (r_count != '0) & out_ready & ~flush;
  assign w_head     = r_mem[w_rd_ptr];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass    = (r_count == '0) & w_enq;
  assign w_out_entry = w_bypass ? w_in_entry : w_head;
`else
  assign w_bypass    = 1'b0;
  assign w_out_entry = w_head;
`endif

  // A bypassed line taken by decode in the same cycle never enters storage.
  assign w_bypass_take = w_bypass & out_ready;
  assign w_wr          = w_enq & ~w_bypass_take;
  assign w_out_valid   = (r_count != '0) | w_bypass;

  // Upper record bits beyond this configuration's widths are always zero.
  assign w_unused = ^w_out_entry;

  fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_inc   (w_wr),
    .i_clr   (flush),
    .o_ptr   (w_wr_ptr)
  );

  fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_inc   (w_deq),
    .i_clr   (flush),
    .o_ptr   (w_rd_ptr)
  );

  // Entry storage write; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[w_wr_ptr] <= w_in_entry;
  end

  // Occupancy, fetch-id counter (survives flush) and post-reset ready flag.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_id       <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_enq) r_id <= r_id + 1'b1;
      if (flush) begin
        r_count <= '0;
      end else if (w_wr && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_deq) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign in_ready        = w_in_ready;
  assign out_valid       = w_out_valid;
  assign count           = r_count;
  assign out_bytes       = w_out_valid ? w_out_entry.bytes[BW-1:0]   : '0;
  assign out_pc          = w_out_valid ? w_out_entry.pc              : '0;
  assign out_width       = w_out_valid ? w_out_entry.width[WW-1:0]   : '0;
  assign out_bpred_taken = w_out_valid & w_out_entry.bpred_taken;
  assign out_bpred_tgt   = w_out_valid ? w_out_entry.bpred_tgt       : '0;
  assign out_id          = w_out_valid ? w_out_entry.id[ID_W-1:0]    : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// Instance u_dut uses DEPTH=4, u_dut2 uses DEPTH=2; both LINE_BYTES=8, ID_W=4.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_bytes;
  logic [31:0] in_pc;
  logic [3:0]  in_width;
  logic        in_bpred_taken;
  logic [31:0] in_bpred_tgt;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_bytes;
  logic [31:0] out_pc;
  logic [3:0]  out_width;
  logic        out_bpred_taken;
  logic [31:0] out_bpred_tgt;
  logic [3:0]  out_id;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  logic        in_valid2;
  logic [31:0] in_pc2;
  logic        in_ready2;
  logic        out_valid2;
  logic [63:0] out_bytes2;
  logic [31:0] out_pc2;
  logic [3:0]  out_width2;
  logic        out_bpred_taken2;
  logic [31:0] out_bpred_tgt2;
  logic [3:0]  out_id2;
  logic        out_ready2;
  logic        flush2;
  logic [1:0]  count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  fetch_queue #(.LINE_BYTES(8), .DEPTH(4), .ID_W(4)) u_dut (
    .CLK             (CLK),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_bytes        (in_bytes),
    .in_pc           (in_pc),
    .in_width        (in_width),
    .in_bpred_taken  (in_bpred_taken),
    .in_bpred_tgt    (in_bpred_tgt),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_bytes       (out_bytes),
    .out_pc          (out_pc),
    .out_width       (out_width),
    .out_bpred_taken (out_bpred_taken),
    .out_bpred_tgt   (out_bpred_tgt),
    .out_id          (out_id),
    .out_ready       (out_ready),
    .flush           (flush),
    .count           (count)
  );

  fetch_queue #(.LINE_BYTES(8), .DEPTH(2), .ID_W(4)) u_dut2 (
    .CLK             (CLK),
    .reset           (reset),
    .in_valid        (in_valid2),
    .in_bytes        (in_bytes),
    .in_pc           (in_pc2),
    .in_width        (in_width),
    .in_bpred_taken  (in_bpred_taken),
    .in_bpred_tgt    (in_bpred_tgt),
    .in_ready        (in_ready2),
    .out_valid       (out_valid2),
    .out_bytes       (out_bytes2),
    .out_pc          (out_pc2),
    .out_width       (out_width2),
    .out_bpred_taken (out_bpred_taken2),
    .out_bpred_tgt   (out_bpred_tgt2),
    .out_id          (out_id2),
    .out_ready       (out_ready2),
    .flush           (flush2),
    .count           (count2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one full cycle, ending on the falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive_line(input logic [31:0] pc, input logic [3:0] width, input logic [63:0] bytes);
    in_valid = 1'b1;
    in_pc    = pc;
    in_width = width;
    in_bytes = bytes;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_bytes = '0; in_pc = '0; in_width = '0;
    in_bpred_taken = 1'b0; in_bpred_tgt = '0;
    out_ready = 1'b0; flush = 1'b0;
    in_valid2 = 1'b0; in_pc2 = '0; out_ready2 = 1'b0; flush2 = 1'b0;

    // Reset held low
    @(negedge CLK);
    @(negedge CLK);
    check("rst_count",     64'(count),     64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_out_id",    64'(out_id),    64'd0);
    reset = 1'b1;
    step();
    check("rel_in_ready",  64'(in_ready),  64'd1);
    check("rel_count",     64'(count),     64'd0);

    // First enqueue
    in_bpred_taken = 1'b1;
    in_bpred_tgt   = 32'hDEAD_0000;
    drive_line(32'h0000_1000, 4'd8, 64'h0102_0304_0506_0708);
    step();
    in_valid = 1'b0;
    in_bpred_taken = 1'b0;
    check("a_out_valid", 64'(out_valid), 64'd1);
    check("a_out_pc",    64'(out_pc),    64'h1000);
    check("a_out_id",    64'(out_id),    64'd0);
    check("a_out_width", 64'(out_width), 64'd8);
    check("a_out_bytes", out_bytes,      64'h0102_0304_0506_0708);
    check("a_bp_taken",  64'(out_bpred_taken), 64'd1);
    check("a_bp_tgt",    64'(out_bpred_tgt),   64'hDEAD_0000);
    check("a_count",     64'(count),     64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("a_deq_count", 64'(count),     64'd0);
    check("a_deq_valid", 64'(out_valid), 64'd0);

    // Partial-width line: only the low three bytes survive
    drive_line(32'h0000_3000, 4'd3, 64'h1122_3344_5566_7788);
    step();
    in_valid = 1'b0;
    check("c_out_bytes", out_bytes,      64'h0000_0000_0066_7788);
    check("c_out_width", 64'(out_width), 64'd3);
    check("c_out_id",    64'(out_id),    64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    // Zero-width line is dropped and consumes no id
    drive_line(32'h0000_3100, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    in_valid = 1'b0;
    check("w0_count", 64'(count),     64'd0);
    check("w0_valid", 64'(out_valid), 64'd0);
    drive_line(32'h0000_3200, 4'd8, 64'h0);
    step();
    in_valid = 1'b0;
    check("w0_next_id", 64'(out_id), 64'd2);

    // Fill to DEPTH with decode stalled
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_line(32'h2000 + 32'(i) * 32'h10, 4'd8, 64'(i));
      step();
    end
    in_valid = 1'b0;
    check("b_in_ready", 64'(in_ready), 64'd0);
    check("b_count",    64'(count),    64'd4);
    drive_line(32'h0000_9999, 4'd8, 64'h0);
    step();
    in_valid = 1'b0;
    check("b_fifth_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b_drain_id", 64'(out_id), 64'(i));
      check("b_drain_pc", 64'(out_pc), 64'(32'h2000 + 32'(i) * 32'h10));
      step();
    end
    out_ready = 1'b0;
    check("b_empty_count", 64'(count),     64'd0);
    check("b_empty_valid", 64'(out_valid), 64'd0);

    // Flush with count=3 and same-cycle enqueue and dequeue
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_line(32'h6000 + 32'(i) * 32'h10, 4'd8, 64'h0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("d_pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    drive_line(32'h0000_7000, 4'd8, 64'h0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("d_flush_count", 64'(count),     64'd0);
    check("d_flush_valid", 64'(out_valid), 64'd0);
    check("d_flush_ready", 64'(in_ready),  64'd1);
    drive_line(32'h0000_7100, 4'd8, 64'h0);
    step();
    in_valid = 1'b0;
    check("d_next_id",  64'(out_id), 64'd4);
    check("d_next_pc",  64'(out_pc), 64'h7100);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("d_drained", 64'(count), 64'd0);

    // Empty queue, line offered while decode is ready
    drive_line(32'h0000_5000, 4'd8, 64'h0);
    out_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_same_valid", 64'(out_valid), 64'd1);
    check("byp_same_pc",    64'(out_pc),    64'h5000);
    check("byp_same_id",    64'(out_id),    64'd5);
    check("byp_same_count", 64'(count),     64'd0);
    @(negedge CLK);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("byp_after_count", 64'(count),     64'd0);
    check("byp_after_valid", 64'(out_valid), 64'd0);
`else
    check("nobyp_same_valid", 64'(out_valid), 64'd0);
    check("nobyp_same_pc",    64'(out_pc),    64'd0);
    @(negedge CLK);
    in_valid = 1'b0;
    check("nobyp_next_valid", 64'(out_valid), 64'd1);
    check("nobyp_next_count", 64'(count),     64'd1);
    check("nobyp_next_id",    64'(out_id),    64'd5);
    step();
    out_ready = 1'b0;
    check("nobyp_deq_count",  64'(count),     64'd0);
`endif

    // DEPTH=2: steady enqueue+dequeue for 20 cycles, ids wrap 15 -> 0
    in_pc2 = 32'h4000;
    in_width = 4'd8;
    in_bytes = 64'hA5A5_A5A5_A5A5_A5A5;
    in_bpred_taken = 1'b0;
    in_bpred_tgt = 32'h0;
    in_valid2 = 1'b1;
    out_ready2 = 1'b0;
    step();
    for (int c = 1; c <= 20; c++) begin
      check("e_count",    64'(count2),     64'd1);
      check("e_in_ready", 64'(in_ready2),  64'd1);
      check("e_id",       64'(out_id2),    64'((c - 1) % 16));
      check("e_pc",       64'(out_pc2),    64'(32'h4000 + 32'(c - 1) * 32'd4));
      in_pc2 = 32'h4000 + 32'(c) * 32'd4;
      out_ready2 = 1'b1;
      step();
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b0;
    check("e_end_count", 64'(count2),           64'd1);
    check("e_end_id",    64'(out_id2),          64'd4);
    check("e_end_pc",    64'(out_pc2),          64'h4050);
    check("e_end_bytes", out_bytes2,            64'hA5A5_A5A5_A5A5_A5A5);
    check("e_end_width", 64'(out_width2),       64'd8);
    check("e_end_bp",    64'(out_bpred_taken2), 64'd0);
    check("e_end_tgt",   64'(out_bpred_tgt2),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter LINE_BYTES, default 8: bytes per fetched line; power of two, range 4..32.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, range 2..16.
REQ-003 Parameter ID_W, default 4: fetch-id width.
REQ-004 Derived WW = log2(LINE_BYTES)+1: width of byte-count fields.
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-007 in_valid  in  1  fetch line offered.
REQ-008 in_bytes  in  8*LINE_BYTES  line bytes; byte 0 in bits [7:0].
REQ-009 in_pc  in  32  linear PC of byte 0.
REQ-010 in_width  in  WW  valid byte count, 0..LINE_BYTES; page-boundary truncation.
REQ-011 in_bpred_taken  in  1  predicted-taken flag for the line.
REQ-012 in_bpred_tgt  in  32  predicted target.
REQ-013 in_ready  out  1  queue can accept a line.
REQ-014 out_valid  out  1  head entry valid.
REQ-015 out_bytes, out_pc, out_width, out_bpred_taken, out_bpred_tgt  out  as inputs  head entry fields.
REQ-016 out_id  out  ID_W  fetch id of head entry.
REQ-017 out_ready  in  1  decode accepts head (decode1 stall_n).
REQ-018 flush  in  1  redirect (mispredict, replay, CS reload); discard all entries.
REQ-019 count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-020 Enqueue SHALL occur iff in_valid & in_ready & ~flush & in_width != 0; in_width == 0 lines are dropped silently.
REQ-021 in_ready SHALL equal (count < DEPTH), independent of out_ready; the full-with-dequeue case is not accepted.
REQ-022 Dequeue SHALL occur iff out_valid & out_ready & ~flush.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged; both pointers advance.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH and never over- or underflow.
REQ-025 Outputs SHALL present the head entry from storage; out_valid = (count != 0), except as given by REQ-033.
REQ-026 out_bytes bytes at index >= out_width SHALL read as 0x00.
REQ-027 Each enqueued entry SHALL capture out_id from a free-running ID_W counter; the counter increments by 1 per enqueue, wraps at 2^ID_W, and is not cleared by flush.
REQ-028 flush SHALL take priority over same-cycle enqueue and dequeue.
REQ-029 Following a flush cycle, count = 0, out_valid = 0 and in_ready = 1; the queue may accept a new line one cycle after flush.
REQ-030 Without bypass, latency from enqueue to out_valid SHALL be 1 cycle.

Reset
REQ-031 While reset = 0: count = 0, both pointers = 0, id counter = 0, out_valid = 0, in_ready = 0; all other outputs are 0.
REQ-032 In the first cycle after reset release, in_ready SHALL be 1; storage contents need not be reset.

Configuration
REQ-033 With FETCH_QUEUE_BYPASS_EN defined: when count = 0 and an enqueue qualifies, outputs SHALL present the input combinationally (out_valid = 1). If out_ready = 1 in that cycle, the line is consumed and not written; otherwise it is written normally. The id counter increments in either case.
REQ-034 Without FETCH_QUEUE_BYPASS_EN, no combinational path from in_* to out_* SHALL exist.

Structure
REQ-035 The entry record (bytes, pc, width, bpred_taken, bpred_tgt, id) and the WW width function SHALL live in shared package fetch_pkg.
REQ-036 One sub-module fq_ptr SHALL implement a wrap-around pointer with increment and clear; fetch_queue instantiates it twice.

Verification
REQ-037 Bench SHALL check reset release, then enqueue pc=0x1000, width=8: next cycle out_valid = 1, out_pc = 0x1000, out_id = 0.
REQ-038 Bench SHALL check fill with out_ready = 0: after DEPTH = 4 enqueues, in_ready = 0, count = 4; a fifth in_valid is ignored and the ids read 0,1,2,3 in order.
REQ-039 Bench SHALL check enqueue with width = 3, bytes 0x1122334455667788: out_bytes = 0x0000000000667788.
REQ-040 Bench SHALL check flush asserted with count = 3, plus same-cycle in_valid and out_ready: next cycle count = 0; the next enqueue gets id 4, not 0.
REQ-041 Bench SHALL check continuous enq/deq for 20 cycles with DEPTH = 2: count stays 1, pointer wrap is correct, and ids wrap 15 -> 0.
REQ-042 Bench SHALL check, with FETCH_QUEUE_BYPASS_EN, empty queue plus in_valid and out_ready: out_valid = 1 in the same cycle and count remains 0.
